// File: rtl/param_cache_ctrl.sv
// param_cache_ctrl: direct-mapped write-through cache with a block-refill miss controller and hit/miss counters
module param_cache_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int WORD_W   = 32,
    parameter int INDEX_W  = 5,
    parameter int OFFSET_W = 2,
    parameter int CNT_W    = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         CpuReq,
    input  logic                         CpuWe,
    input  logic [ADDR_W-1:0]            CpuAddr,
    input  logic [WORD_W-1:0]            CpuWData,
    input  logic                         Flush,
    output logic                         CpuReady,
    output logic                         CpuDone,
    output logic [WORD_W-1:0]            CpuRData,
    output logic                         MemRdReq,
    output logic [ADDR_W-OFFSET_W-1:0]   MemRdAddr,
    input  logic                         MemRdValid,
    input  logic [(WORD_W<<OFFSET_W)-1:0] MemRdData,
    output logic                         MemWrReq,
    output logic [ADDR_W-1:0]            MemWrAddr,
    output logic [WORD_W-1:0]            MemWrData,
    input  logic                         MemWrAck,
    output logic [CNT_W-1:0]             HitCount,
    output logic [CNT_W-1:0]             MissCount
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;
    localparam int BLK_W = ADDR_W - OFFSET_W;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q [LINES];
    logic [WORD_W-1:0]   data_q [LINES][WORDS];
    logic                done_q, done_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;
    logic                rd_req_q, rd_req_d;
    logic [BLK_W-1:0]    rd_addr_q, rd_addr_d;
    logic [OFFSET_W-1:0] off_q, off_d;
    logic                wr_req_q, wr_req_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]   wr_data_q, wr_data_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic [OFFSET_W-1:0] req_off;
    logic [INDEX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic hit, acc, rd_hit, rd_miss, wr_acc, fill_done, wr_done;

    assign req_tag   = CpuAddr[ADDR_W-1 -: TAG_W];
    assign req_idx   = CpuAddr[OFFSET_W +: INDEX_W];
    assign req_off   = CpuAddr[OFFSET_W-1:0];
    assign fill_idx  = rd_addr_q[INDEX_W-1:0];
    assign fill_tag  = rd_addr_q[BLK_W-1 -: TAG_W];
    assign CpuReady  = (state_q == IDLE) & ~Flush;
    assign hit       = valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    assign acc       = CpuReq & CpuReady;
    assign rd_hit    = acc & ~CpuWe & hit;
    assign rd_miss   = acc & ~CpuWe & ~hit;
    assign wr_acc    = acc & CpuWe;
    assign fill_done = (state_q == FILL) & MemRdValid;
    assign wr_done   = (state_q == WRITE) & MemWrAck;

    always_comb begin
        state_d    = rd_miss ? FILL : wr_acc ? WRITE : (fill_done | wr_done) ? IDLE : state_q;
        valid_d    = (state_q == IDLE && Flush) ? '0
                   : fill_done ? (valid_q | (LINES'(1) << fill_idx)) : valid_q;
        done_d     = rd_hit | fill_done | wr_done;
        rdata_d    = rd_hit ? data_q[req_idx][req_off]
                   : fill_done ? MemRdData[off_q*WORD_W +: WORD_W] : rdata_q;
        rd_req_d   = rd_miss | (rd_req_q & ~fill_done);
        rd_addr_d  = rd_miss ? CpuAddr[ADDR_W-1:OFFSET_W] : rd_addr_q;
        off_d      = rd_miss ? req_off : off_q;
        wr_req_d   = wr_acc | (wr_req_q & ~wr_done);
        wr_addr_d  = wr_acc ? CpuAddr : wr_addr_q;
        wr_data_d  = wr_acc ? CpuWData : wr_data_q;
        hit_cnt_d  = (acc & hit & (hit_cnt_q != '1)) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
        miss_cnt_d = (acc & ~hit & (miss_cnt_q != '1)) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            done_q     <= 1'b0;
            rdata_q    <= '0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            off_q      <= '0;
            wr_req_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            rd_req_q   <= rd_req_d;
            rd_addr_q  <= rd_addr_d;
            off_q      <= off_d;
            wr_req_q   <= wr_req_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (fill_done) begin
                tag_q[fill_idx] <= fill_tag;
                for (int w = 0; w < WORDS; w++)
                    data_q[fill_idx][w] <= MemRdData[w*WORD_W +: WORD_W];
            end
            if (wr_acc & hit)
                data_q[req_idx][req_off] <= CpuWData;
        end
    end

    assign CpuDone   = done_q;
    assign CpuRData  = rdata_q;
    assign MemRdReq  = rd_req_q;
    assign MemRdAddr = rd_addr_q;
    assign MemWrReq  = wr_req_q;
    assign MemWrAddr = wr_addr_q;
    assign MemWrData = wr_data_q;
    assign HitCount  = hit_cnt_q;
    assign MissCount = miss_cnt_q;
endmodule

// File: tb/tb_param_cache_ctrl.sv
// tb_param_cache_ctrl: directed table, corner sequences and random traffic against a block-level cache model
module tb_param_cache_ctrl;
    logic         CLK = 0, RST = 1, CpuReq = 0, CpuWe = 0, Flush = 0;
    logic [9:0]   CpuAddr = 0;
    logic [31:0]  CpuWData = 0;
    logic         CpuReady, CpuDone, MemRdReq, MemRdValid = 0, MemWrReq, MemWrAck = 0;
    logic [31:0]  CpuRData, MemWrData;
    logic [7:0]   MemRdAddr;
    logic [127:0] MemRdData = 0;
    logic [9:0]   MemWrAddr;
    logic [15:0]  HitCount, MissCount;

    param_cache_ctrl dut (
        .CLK(CLK), .RST(RST), .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr),
        .CpuWData(CpuWData), .Flush(Flush), .CpuReady(CpuReady), .CpuDone(CpuDone),
        .CpuRData(CpuRData), .MemRdReq(MemRdReq), .MemRdAddr(MemRdAddr),
        .MemRdValid(MemRdValid), .MemRdData(MemRdData), .MemWrReq(MemWrReq),
        .MemWrAddr(MemWrAddr), .MemWrData(MemWrData), .MemWrAck(MemWrAck),
        .HitCount(HitCount), .MissCount(MissCount)
    );

    always #5 CLK = ~CLK;

    int total = 0, bad = 0;
    int exp_hits = 0, exp_misses = 0;
    logic [31:0] mem [1024];
    int cblk [32];

    typedef struct {
        bit we; logic [9:0] addr; logic [31:0] wd; int lat; logic [31:0] exp_rd; bit exp_miss;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic model_flush();
        for (int i = 0; i < 32; i++) cblk[i] = -1;
    endtask

    task automatic check_counts();
        chk("hit_count", 32'(HitCount), exp_hits);
        chk("miss_count", 32'(MissCount), exp_misses);
    endtask

    task automatic run(input bit we, input logic [9:0] a, input logic [31:0] wd, input int lat,
                       input logic [31:0] exp_rd, input bit exp_miss);
        int n = 0, rpend = 0, wpend = 0;
        bit done = 0, saw = 0;
        logic [31:0] rd = 0;
        @(negedge CLK);
        chk("ready", CpuReady, 1);
        CpuReq = 1; CpuWe = we; CpuAddr = a; CpuWData = wd;
        @(posedge CLK); #1 CpuReq = 0;
        while (!done && n < 40) begin
            @(negedge CLK); n++;
            MemRdValid = 0; MemWrAck = 0;
            if (CpuDone) begin
                done = 1; rd = CpuRData;
            end else if (MemRdReq) begin
                saw = 1; rpend++;
                if (rpend == 1) chk("rd_addr", 32'(MemRdAddr), 32'(a[9:2]));
                if (rpend == lat) begin
                    MemRdValid = 1;
                    for (int k = 0; k < 4; k++) MemRdData[k*32 +: 32] = mem[{MemRdAddr, 2'(k)}];
                end
            end else if (MemWrReq) begin
                wpend++;
                if (wpend == lat) begin
                    chk("wr_addr", 32'(MemWrAddr), 32'(a));
                    chk("wr_data", MemWrData, wd);
                    MemWrAck = 1; mem[a] = wd;
                end
            end
        end
        MemRdValid = 0; MemWrAck = 0;
        chk("done_seen", 32'(done), 1);
        if (!we) chk("rdata", rd, exp_rd);
        chk("mem_rd_used", 32'(saw), 32'(!we && exp_miss));
        if (we) chk("wr_held", wpend, lat);
        if (!we && exp_miss) chk("rd_held", rpend, lat);
        if (!we && !exp_miss) chk("hit_latency", n, 1);
        if (exp_miss) exp_misses++; else exp_hits++;
        if (!we && exp_miss) cblk[a[6:2]] = int'(a[9:2]);
        @(negedge CLK);
        chk("done_pulse", 32'(CpuDone), 0);
        check_counts();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[10'h084] = 32'h11111111; mem[10'h085] = 32'h22222222;
        mem[10'h086] = 32'h33333333; mem[10'h087] = 32'h44444444;
        model_flush();
        vecs[0] = '{0, 10'h085, 0, 2, 32'h22222222, 1};
        vecs[1] = '{0, 10'h084, 0, 1, 32'h11111111, 0};
        vecs[2] = '{1, 10'h086, 32'hDEADBEEF, 3, 0, 0};
        vecs[3] = '{0, 10'h086, 0, 1, 32'hDEADBEEF, 0};
        vecs[4] = '{0, 10'h185, 0, 1, 32'hA5000185, 1};
        vecs[5] = '{0, 10'h085, 0, 3, 32'h22222222, 1};
        vecs[6] = '{1, 10'h300, 32'h12345678, 1, 0, 1};
        vecs[7] = '{0, 10'h300, 0, 2, 32'h12345678, 1};
        vecs[8] = '{0, 10'h301, 0, 1, 32'hA5000301, 0};

        repeat (2) @(posedge CLK);
        #1 RST = 0;
        @(negedge CLK);
        chk("rst_ready", 32'(CpuReady), 1);
        chk("rst_done", 32'(CpuDone), 0);
        chk("rst_rdata", CpuRData, 0);
        chk("rst_rdreq", 32'(MemRdReq), 0);
        chk("rst_wrreq", 32'(MemWrReq), 0);
        chk("rst_rdaddr", 32'(MemRdAddr), 0);
        check_counts();

        foreach (vecs[i]) run(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].lat, vecs[i].exp_rd, vecs[i].exp_miss);

        // back-to-back hits on the resident 0x300 block
        @(negedge CLK); CpuReq = 1; CpuWe = 0; CpuAddr = 10'h300;
        @(negedge CLK); chk("b2b_done0", 32'(CpuDone), 1); chk("b2b_rd0", CpuRData, 32'h12345678);
        CpuAddr = 10'h301;
        @(negedge CLK); chk("b2b_done1", 32'(CpuDone), 1); chk("b2b_rd1", CpuRData, 32'hA5000301);
        CpuReq = 0; exp_hits += 2;
        @(negedge CLK); check_counts();

        @(negedge CLK); Flush = 1; CpuReq = 1; CpuAddr = 10'h084;
        #1 chk("flush_ready", 32'(CpuReady), 0);
        @(posedge CLK); #1 Flush = 0; CpuReq = 0;
        @(negedge CLK);
        chk("flush_done", 32'(CpuDone), 0);
        chk("flush_rdreq", 32'(MemRdReq), 0);
        check_counts();
        model_flush();
        run(0, 10'h084, 0, 2, 32'h11111111, 1);

        @(negedge CLK); CpuReq = 1; CpuWe = 0; CpuAddr = 10'h185;
        @(posedge CLK); #1 CpuReq = 0;
        @(negedge CLK); chk("fill_rdreq", 32'(MemRdReq), 1);
        RST = 1;
        @(posedge CLK); #1 RST = 0;
        @(negedge CLK);
        chk("rstfill_rdreq", 32'(MemRdReq), 0);
        chk("rstfill_ready", 32'(CpuReady), 1);
        exp_hits = 0; exp_misses = 0; model_flush();
        check_counts();
        MemRdValid = 1;
        for (int k = 0; k < 4; k++) MemRdData[k*32 +: 32] = mem[{8'h61, 2'(k)}];
        @(posedge CLK); #1 MemRdValid = 0;
        @(negedge CLK);
        chk("late_valid_done", 32'(CpuDone), 0);
        chk("late_valid_ready", 32'(CpuReady), 1);
        run(0, 10'h085, 0, 2, 32'h22222222, 1);

        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(9) == 0) begin
                @(negedge CLK); Flush = 1;
                @(posedge CLK); #1 Flush = 0;
                model_flush();
            end else begin
                logic [9:0] a;
                bit we, miss;
                a = {3'($urandom), 3'b000, 2'($urandom), 2'($urandom)};
                we = $urandom_range(2) == 0;
                miss = cblk[a[6:2]] != int'(a[9:2]);
                run(we, a, $urandom, $urandom_range(1, 3), mem[a], miss);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
